// File: rtl/alu_defs_pkg.sv
// Shared constants for the ALU arbiter: widths, FSM state encoding and ALU opcodes.
package alu_defs;
  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-input round-robin grant, purely combinational; one-hot or zero output.
// With both requesting, the grant goes to whichever requester did not win last.
module rr_arbiter2 (
  input  logic [1:0] i_req_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);
  always_comb begin
    o_grant = 2'b00;
    case (i_req_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Accept -> EXEC (ALU settles) -> RESP held until rsp_ready; one operation in flight.
module alu_arbiter #(
  parameter int DATA_W = alu_defs::DATA_W,
  parameter int OP_W   = alu_defs::OP_W,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [2*OP_W-1:0]   req_opcode,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_opcode,
  input  logic [DATA_W-1:0]   alu_resultado,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_resultado,
  output logic                rsp_zero,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);
  import alu_defs::*;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_gnt_id;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [OP_W-1:0]     r_alu_opcode;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_resultado;
  logic                r_rsp_zero;
  logic [CNT_W-1:0]    r_op_count;

  logic [1:0]          w_grant;
  logic                w_gnt_id;
  logic                w_accept;

  rr_arbiter2 u_rr (
    .i_req_valid  (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_gnt_id  = w_grant[1];
  // Gated by rst_n so no requester can see a handshake while reset is held.
  assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : 2'b00;
  assign w_accept  = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_last_grant    <= 1'b1;
      r_gnt_id        <= 1'b0;
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_alu_opcode    <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_id        <= 1'b0;
      r_rsp_resultado <= '0;
      r_rsp_zero      <= 1'b0;
      r_op_count      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a      <= w_gnt_id ? req_a[2*DATA_W-1:DATA_W]  : req_a[DATA_W-1:0];
            r_alu_b      <= w_gnt_id ? req_b[2*DATA_W-1:DATA_W]  : req_b[DATA_W-1:0];
            r_alu_opcode <= w_gnt_id ? req_opcode[2*OP_W-1:OP_W] : req_opcode[OP_W-1:0];
            r_gnt_id     <= w_gnt_id;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_resultado <= alu_resultado;
          r_rsp_zero      <= alu_zero;
          r_rsp_id        <= r_gnt_id;
          r_rsp_valid     <= 1'b1;
          r_state         <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_last_grant <= r_rsp_id;
            r_op_count   <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_opcode    = r_alu_opcode;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_rsp_id;
  assign rsp_resultado = r_rsp_resultado;
  assign rsp_zero      = r_rsp_zero;
  assign busy          = (r_state != ST_IDLE);
  assign op_count      = r_op_count;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomized bench for alu_arbiter with a stand-in ALU and a behavioural reference.
module tb_alu_arbiter;
  import alu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_opcode;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_resultado;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [7:0]  rsp_resultado;
  logic [15:0] op_count;

  int n_cmp = 0;
  int n_err = 0;
  logic        m_last;
  logic [15:0] m_count;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_resultado(alu_resultado), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_resultado(rsp_resultado), .rsp_zero(rsp_zero),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    int r;
    case (op)
      OP_ADD:  r = int'(a) + int'(b);
      OP_SUB:  r = int'(a) - int'(b);
      OP_AND:  r = int'(a) & int'(b);
      OP_OR:   r = int'(a) | int'(b);
      OP_XOR:  r = int'(a) ^ int'(b);
      OP_NOT:  r = ~int'(a);
      OP_SHL:  r = int'(a) * 2;
      OP_SHR:  r = int'(a) / 2;
      default: r = 0;
    endcase
    return 8'(r & 255);
  endfunction

  // Stand-in for the external ALU, wired to the registered operand ports.
  always_comb begin
    alu_resultado = alu_ref(alu_a, alu_b, alu_opcode);
    alu_zero      = (alu_resultado == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation; expectations come from the arbitration rule and alu_ref.
  task automatic do_op(input logic [1:0] mask, input int bp,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] o0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] o1);
    int         w;
    logic [7:0] wa, wb, er;
    logic [3:0] wo;
    req_a      = {a1, a0};
    req_b      = {b1, b0};
    req_opcode = {o1, o0};
    w  = (mask == 2'b11) ? (m_last ? 0 : 1) : (mask[1] ? 1 : 0);
    wa = (w == 1) ? a1 : a0;
    wb = (w == 1) ? b1 : b0;
    wo = (w == 1) ? o1 : o0;
    er = alu_ref(wa, wb, wo);
    req_valid = mask;
    rsp_ready = (bp == 0);
    #1;
    chk("idle_req_ready", 32'(req_ready), (w == 1) ? 32'h2 : 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b11;
    chk("exec_busy", 32'(busy), 32'h1);
    chk("exec_req_ready", 32'(req_ready), 32'h0);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("exec_alu_a", 32'(alu_a), 32'(wa));
    chk("exec_alu_b", 32'(alu_b), 32'(wb));
    chk("exec_alu_op", 32'(alu_opcode), 32'(wo));
    @(posedge clk); #1;
    chk("resp_valid", 32'(rsp_valid), 32'h1);
    chk("resp_id", 32'(rsp_id), 32'(w));
    chk("resp_res", 32'(rsp_resultado), 32'(er));
    chk("resp_zero", 32'(rsp_zero), (er == 8'h00) ? 32'h1 : 32'h0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_res", 32'(rsp_resultado), 32'(er));
      chk("bp_id", 32'(rsp_id), 32'(w));
      chk("bp_busy", 32'(busy), 32'h1);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    m_count = m_count + 16'd1;
    m_last  = (w == 1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("done_valid", 32'(rsp_valid), 32'h0);
    chk("done_busy", 32'(busy), 32'h0);
    chk("done_count", 32'(op_count), 32'(m_count));
    chk("done_hold_a", 32'(alu_a), 32'(wa));
  endtask

  initial begin
    int         acc_cyc[$];
    int         acc_id[$];
    logic [8:0] exp_rsp[$];
    logic [8:0] got;
    int         n_acc, n_rsp;
    logic       e_id;
    logic [7:0] ca[2], cb[2];
    logic [3:0] co[2];

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_opcode = '0;
    m_last = 1'b1; m_count = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(op_count), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_rsp_res", 32'(rsp_resultado), 32'h0);
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_valid_ready", 32'(req_ready), 32'h0);

    do_op(2'b01, 0, 8'h0A, 8'h02, OP_ADD, 8'h00, 8'h00, OP_ADD);
    chk("single_res", 32'(rsp_resultado), 32'h0C);
    chk("single_id", 32'(rsp_id), 32'h0);
    chk("single_count", 32'(op_count), 32'h1);

    do_op(2'b10, 0, 8'h00, 8'h00, OP_ADD, 8'h05, 8'h05, OP_SUB);
    chk("zero_res", 32'(rsp_resultado), 32'h00);
    chk("zero_flag", 32'(rsp_zero), 32'h1);
    chk("zero_id", 32'(rsp_id), 32'h1);

    for (int k = 0; k < 12; k++)
      do_op(2'($urandom_range(1, 3)), $urandom_range(0, 3),
            8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)),
            8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)));

    // Contention: both valid continuously; grants must alternate every 3 cycles.
    for (int i = 0; i < 2; i++) begin
      ca[i] = 8'($urandom); cb[i] = 8'($urandom); co[i] = 4'($urandom_range(0, 7));
    end
    req_a = {ca[1], ca[0]}; req_b = {cb[1], cb[0]}; req_opcode = {co[1], co[0]};
    req_valid = 2'b11; rsp_ready = 1'b1;
    n_acc = 0; n_rsp = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        acc_cyc.push_back(c);
        acc_id.push_back(req_ready[1] ? 1 : 0);
        exp_rsp.push_back({req_ready[1],
                           alu_ref(ca[req_ready[1]], cb[req_ready[1]], co[req_ready[1]])});
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        got = exp_rsp.size() > 0 ? exp_rsp.pop_front() : 9'h1FF;
        chk("cont_rsp", {23'd0, rsp_id, rsp_resultado}, 32'(got));
        n_rsp++;
      end
      @(posedge clk); #1;
      if (n_acc >= 6) req_valid = 2'b00;
      if (n_rsp == 6) break;
    end
    rsp_ready = 1'b0;
    chk("cont_accepts", 32'(n_acc), 32'd6);
    chk("cont_responses", 32'(n_rsp), 32'd6);
    e_id = ~m_last;
    for (int k = 0; k < acc_id.size(); k++) begin
      chk("cont_order", 32'(acc_id[k]), 32'(e_id));
      if (k > 0) chk("cont_interval", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
      e_id = ~e_id;
    end
    m_last  = ~e_id;
    m_count = m_count + 16'd6;
    chk("cont_count", 32'(op_count), 32'(m_count));

    // Five cycles of backpressure, then both valid: the other requester must win.
    do_op(2'b01, 5, 8'h33, 8'h11, OP_XOR, 8'h00, 8'h00, OP_ADD);
    do_op(2'b11, 0, 8'h10, 8'h01, OP_ADD, 8'h80, 8'h00, OP_SHR);
    chk("bp_next_id", 32'(rsp_id), 32'h1);

    // Reset during EXEC discards the operation.
    req_a = 16'h0909; req_b = 16'h0101; req_opcode = 8'h00;
    req_valid = 2'b01; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    chk("midrst_alu_a", 32'(alu_a), 32'h0);
    chk("midrst_alu_op", 32'(alu_opcode), 32'h0);
    chk("midrst_count", 32'(op_count), 32'h0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'h0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    m_last = 1'b1; m_count = 16'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("postrst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    do_op(2'b11, 0, 8'hFF, 8'h01, OP_ADD, 8'h01, 8'h01, OP_ADD);
    chk("postrst_first_id", 32'(rsp_id), 32'h0);

    // Counter wrap: preload 0xFFFF, the next completion must read 0x0000.
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    #1;
    chk("wrap_preload", 32'(op_count), 32'hFFFF);
    m_count = 16'hFFFF;
    do_op(2'b10, 1, 8'h00, 8'h00, OP_ADD, 8'h0F, 8'hF0, OP_OR);
    chk("wrap_count", 32'(op_count), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` (8-bit `a`/`b`, 4-bit `opcode` → 8-bit `resultado`, `zero`) between two requesters.
- Each requester issues operations over a valid/ready handshake; grants are round-robin.
- Grant → operand registers → result capture → one shared response channel tagged with requester id.
- The `alu` is instantiated beside this block and connected through the `alu_*` ports.

Parameters:
- DATA_W, 8, operand/result width; must match `alu`.
- OP_W, 4, opcode width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_a  in  2*DATA_W  operand a; slice i belongs to requester i.
- req_b  in  2*DATA_W  operand b; slice i.
- req_opcode  in  2*OP_W  opcode; slice i.
- alu_a  out  DATA_W  registered operand a to `alu`.
- alu_b  out  DATA_W  registered operand b to `alu`.
- alu_opcode  out  OP_W  registered opcode to `alu`.
- alu_resultado  in  DATA_W  `alu` result.
- alu_zero  in  1  `alu` zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  1  requester that owns the response.
- rsp_resultado  out  DATA_W  captured result.
- rsp_zero  out  1  captured zero flag.
- busy  out  1  high whenever state != IDLE.
- op_count  out  CNT_W  completed responses; wraps modulo 2^CNT_W.

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - state=IDLE; last_grant=1, so requester 0 wins first.
  - alu_a/alu_b/alu_opcode=0; rsp_valid=0, rsp_id=0, rsp_resultado=0, rsp_zero=0.
  - op_count=0; busy=0; req_ready=0.
- **FSM states:** IDLE → EXEC → RESP → IDLE.
- **IDLE:**
  - req_ready is combinational from state, req_valid and last_grant.
  - Only one valid → that requester is granted.
  - Both valid → grant goes to requester != last_grant.
  - Granted bit of req_ready=1 in the same cycle; the handshake completes on valid&&ready.
  - At that edge: capture the granted slice into alu_a/alu_b/alu_opcode, latch grant id, go EXEC.
  - No valid → stay IDLE; req_ready=0.
- **EXEC:**
  - Exactly one cycle for `alu` to settle.
  - At the edge: rsp_resultado←alu_resultado, rsp_zero←alu_zero, rsp_id←grant id, rsp_valid←1; go RESP.
  - req_ready=0.
- **RESP:**
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid←0, last_grant←rsp_id, op_count←op_count+1, go IDLE.
  - req_ready=0.
- **Latency:** request accept edge → rsp_valid high two edges later. Minimum issue interval is 3 cycles (zero backpressure).
- **Operand hold:** alu_a/alu_b/alu_opcode keep their last value outside EXEC; they are not cleared after completion.
- **Requester rules:**
  - Must hold req_a/req_b/req_opcode stable while req_valid && !req_ready.
  - Deasserting req_valid before grant is legal; no grant results.
- **Fairness:** with both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- **op_count:** wraps 0xFFFF→0x0000, no saturation.
- **Reset mid-operation:** in-flight operation discarded, no response emitted, all state returns to reset values.
- **Unused states:** a 2-bit state encoding's unused value goes to IDLE.

Decomposition:
- Shared package/header `alu_defs`:
  - DATA_W, OP_W constants.
  - State encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - Named opcode constants shared with `alu` and benches.
- Sub-module `rr_arbiter2`: 2-input combinational round-robin grant from req_valid and last_grant, outputs a one-hot grant.
- The rest (FSM, operand/response registers, counter) stays in `alu_arbiter`.
- `alu` is not instantiated inside; the top level wires it.

Test Plan:
- **Single request:** after reset, requester 0 sends a=0x0A, b=0x02, opcode=4'h0 (add); rsp_ready=1.
  - req_ready[0]=1 in the same cycle.
  - rsp_valid two edges later with rsp_id=0, rsp_resultado=0x0C, rsp_zero=0; op_count=1.
- **Zero flag:** requester 1 sends a=0x05, b=0x05, opcode=4'h1 (sub).
  - rsp_id=1, rsp_resultado=0x00, rsp_zero=1.
- **Contention:** both valid continuously for 6 operations, rsp_ready=1.
  - Grant order 0,1,0,1,0,1; one accept every 3 cycles; op_count=6.
- **Backpressure:** rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_* stable, busy=1, req_ready=0 throughout.
  - Completes on the cycle rsp_ready rises; next grant goes to the other requester.
- **Reset mid-op:** assert rst_n=0 during EXEC.
  - rsp_valid=0 immediately (async); all outputs at reset values; no response appears after release.
- **Counter wrap:** run 65536 operations (or force op_count=0xFFFF in the bench).
  - Next completion gives op_count=0x0000.
